jtframe_sdram_arbiter: RTL and testbench
========================================

Name: jtframe_sdram_arbiter

Overview:
Shares one SDRAM controller port between ROM download writes, periodic auto-refresh and SLOTS game read requesters. It sits between the ioctl download path / game ROM fetch logic and the SDRAM command sequencer that drives SDRAM_A/BA/DQ. It serialises all accesses with a single-outstanding-transaction FSM. Read slots are served round-robin.

Parameters:
SLOTS, 3, number of game read requesters (1..4)
AW, 22, SDRAM word address width
REFRESH_CYCLES, 384, clk cycles between refresh requests (8 us at 48 MHz)

Ports:
clk  in  1  system clock (48 MHz)
rst_n  in  1  asynchronous active-low reset
downloading  in  1  ROM download in progress; blocks game reads
ioctl_addr  in  22  download byte address
ioctl_data  in  8  download byte
ioctl_wr  in  1  one-cycle download byte strobe
slot_addr  in  SLOTS*AW  per-slot word address, slot i at [i*AW +: AW]
slot_req  in  SLOTS  level request, held until slot_ok
slot_ack  out  SLOTS  one-cycle pulse: request accepted by controller
slot_ok  out  SLOTS  one-cycle pulse: slot_dout valid for that slot
slot_dout  out  16  read data, held until next read completes
wr_overrun  out  1  sticky: ioctl_wr arrived while write buffer full
sdram_addr  out  AW  controller address
sdram_rd  out  1  read request, held until sdram_ack
sdram_wr  out  1  write request, held until sdram_ack
sdram_refresh  out  1  refresh request, held until sdram_ack
sdram_din  out  16  write data
sdram_dqm  out  2  write byte mask, active high (bit0 masks low byte)
sdram_ack  in  1  controller accepted the current command
sdram_rdy  in  1  one-cycle pulse: read data on sdram_dout
sdram_dout  in  16  read data

Behaviour:
- Reset (async, rst_n low): all outputs 0, sdram_dqm=2'b11, FSM IDLE, write buffer empty, RR pointer 0, refresh counter 0, wr_overrun 0.
- Write buffer: one entry. ioctl_wr latches {addr,data}, sets full. If full and not being drained that cycle -> drop byte, set wr_overrun (cleared only by reset). Drain and new strobe in same cycle -> buffer stays full with the new byte.
- Write mapping: sdram_addr={1'b0,addr[21:1]}; sdram_din={data,data}; addr[0]=0 -> dqm=2'b10, addr[0]=1 -> dqm=2'b01.
- Refresh counter counts every clk; at REFRESH_CYCLES-1 wraps to 0 and sets refresh_pend (already set -> stays set, no queueing).
- FSM states: IDLE, WRITE, READ, RDWAIT, REFRESH.
- IDLE priority, evaluated each cycle: buffer full -> WRITE; else refresh_pend -> REFRESH; else !downloading and any slot_req -> READ for the first requesting slot at or after RR pointer (wrapping); else stay.
- Command outputs are registered: request seen in IDLE at cycle n -> sdram_rd/wr/refresh high from cycle n+1.
- WRITE: sdram_wr held; on sdram_ack drop sdram_wr, clear buffer, -> IDLE.
- REFRESH: sdram_refresh held; on sdram_ack drop it, clear refresh_pend, -> IDLE.
- READ: sdram_addr latched from selected slot; sdram_rd held; on sdram_ack pulse slot_ack[sel], drop sdram_rd, -> RDWAIT.
- RDWAIT: on sdram_rdy latch slot_dout, pulse slot_ok[sel] next cycle, RR pointer = sel+1 mod SLOTS, -> IDLE. Minimum gap between successive commands: 1 IDLE cycle.
- slot_req dropped mid-transaction: the transaction still completes and slot_ok still pulses.
- sdram_ack with no command pending, or sdram_rdy outside RDWAIT: ignored.
- downloading rising during READ/RDWAIT: the current read completes; no new reads start.
- At most one bit of slot_ack or slot_ok is high in any cycle.

Decomposition:
- jtframe_sdram_pkg: FSM state encoding, DQM constants, default REFRESH_CYCLES.
- Sub-module jtframe_rr_pick: combinational round-robin selector (req vector and pointer in; one-hot grant and index out). Reused by other jtframe arbiters.

Test Plan:
- Download: ioctl_wr addr 0x000005, data 0xA5 -> sdram_wr with addr 0x000002, din 0xA5A5, dqm 2'b01. Buffer empties after sdram_ack.
- Overrun: two ioctl_wr 1 cycle apart with sdram_ack held low -> wr_overrun=1, first byte written, second byte dropped.
- Round-robin: slots 0,1,2 all requesting continuously, controller acking immediately -> grant order 0,1,2,0. Each slot_ok carries the matching sdram_dout (0x1111, 0x2222, 0x3333).
- Refresh: REFRESH_CYCLES=16, no other traffic -> sdram_refresh asserted every 16 cycles. With a read in RDWAIT, refresh issues only after slot_ok.
- Priority: write buffer full, refresh_pend and slot_req all present in IDLE -> order is WRITE, REFRESH, READ.
- Reset mid-RDWAIT: rst_n low -> all outputs 0 and dqm=2'b11 immediately. A later sdram_rdy produces no slot_ok.

Source files
------------

// File: rtl/jtframe_sdram_pkg.sv
// rtl/jtframe_sdram_pkg.sv - shared types and constants for the SDRAM port arbiter
// Contents: arbiter FSM state encoding, SDRAM byte-mask constants,
// default refresh interval and an index-width helper.
package jtframe_sdram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_READ    = 3'd2,
        ST_RDWAIT  = 3'd3,
        ST_REFRESH = 3'd4
    } arb_state_e;

    // DQM is active high: a set bit masks that byte lane.
    localparam logic [1:0] DQM_NONE    = 2'b11;  // nothing written
    localparam logic [1:0] DQM_WR_LOW  = 2'b10;  // write low byte only
    localparam logic [1:0] DQM_WR_HIGH = 2'b01;  // write high byte only
    localparam logic [1:0] DQM_WORD    = 2'b00;  // full word (reads)

    // 8 us at 48 MHz
    localparam int REFRESH_DEFAULT = 384;

    // Width of an index into n items, never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/jtframe_sdram_arbiter_if.sv
// rtl/jtframe_sdram_arbiter_if.sv - bundle of all arbiter-facing signals
// Groups: download path (downloading, ioctl_*), game read slots (slot_*),
// SDRAM command sequencer side (sdram_*). The master modport is the
// arbiter's view; the slave modport is the view of the surrounding logic.
interface jtframe_sdram_arbiter_if #(
    parameter int SLOTS = 3,
    parameter int AW    = 22
);
    logic                  downloading;
    logic [21:0]           ioctl_addr;
    logic [7:0]            ioctl_data;
    logic                  ioctl_wr;
    logic [SLOTS*AW-1:0]   slot_addr;
    logic [SLOTS-1:0]      slot_req;
    logic [SLOTS-1:0]      slot_ack;
    logic [SLOTS-1:0]      slot_ok;
    logic [15:0]           slot_dout;
    logic                  wr_overrun;
    logic [AW-1:0]         sdram_addr;
    logic                  sdram_rd;
    logic                  sdram_wr;
    logic                  sdram_refresh;
    logic [15:0]           sdram_din;
    logic [1:0]            sdram_dqm;
    logic                  sdram_ack;
    logic                  sdram_rdy;
    logic [15:0]           sdram_dout;

    modport master (
        input  downloading, ioctl_addr, ioctl_data, ioctl_wr,
        input  slot_addr, slot_req,
        output slot_ack, slot_ok, slot_dout, wr_overrun,
        output sdram_addr, sdram_rd, sdram_wr, sdram_refresh, sdram_din, sdram_dqm,
        input  sdram_ack, sdram_rdy, sdram_dout
    );

    modport slave (
        output downloading, ioctl_addr, ioctl_data, ioctl_wr,
        output slot_addr, slot_req,
        input  slot_ack, slot_ok, slot_dout, wr_overrun,
        input  sdram_addr, sdram_rd, sdram_wr, sdram_refresh, sdram_din, sdram_dqm,
        output sdram_ack, sdram_rdy, sdram_dout
    );

endinterface

// File: rtl/jtframe_rr_pick.sv
// rtl/jtframe_rr_pick.sv - combinational round-robin selector
// Ports: req (request vector), ptr (first index to consider),
// grant (one-hot winner), idx (winner index), any (some request present).
// The search starts at ptr and wraps, so the winner is the first
// requester at or after ptr.
module jtframe_rr_pick
    import jtframe_sdram_pkg::*;
#(
    parameter  int N  = 3,
    localparam int IW = idx_width(N)
)(
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        logic [IW:0] j;  // one extra bit so ptr+i cannot overflow before the wrap
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = '0;
        for (int i = 0; i < N; i++) begin
            j = {1'b0, ptr} + (IW+1)'(i);
            if (j >= (IW+1)'(N)) begin
                j = j - (IW+1)'(N);
            end
            if (!any && req[j[IW-1:0]]) begin
                any               = 1'b1;
                grant[j[IW-1:0]]  = 1'b1;
                idx               = j[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/jtframe_sdram_arbiter.sv
// rtl/jtframe_sdram_arbiter.sv - one-outstanding-command SDRAM port arbiter
// Shares one controller port between ROM download writes, auto-refresh and
// SLOTS round-robin game readers.
// Ports: clk, rst_n (async, active low), bus (master modport of
// jtframe_sdram_arbiter_if carrying download, slot and sdram signals).
module jtframe_sdram_arbiter
    import jtframe_sdram_pkg::*;
#(
    parameter int SLOTS          = 3,
    parameter int AW             = 22,
    parameter int REFRESH_CYCLES = REFRESH_DEFAULT
)(
    input  logic                   clk,
    input  logic                   rst_n,
    jtframe_sdram_arbiter_if.master bus
);

    localparam int IW = idx_width(SLOTS);
    localparam int CW = idx_width(REFRESH_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_CYCLES - 1);

    arb_state_e       state, state_nxt;

    // single-entry download write buffer
    logic             wbuf_full;
    logic [21:0]      wbuf_addr;
    logic [7:0]       wbuf_data;
    logic             overrun_q;

    logic [CW-1:0]    ref_cnt;
    logic             ref_pend;

    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    sel;
    logic [SLOTS-1:0] sel_oh;

    logic [AW-1:0]    addr_q;
    logic [15:0]      din_q;
    logic [1:0]       dqm_q;
    logic [SLOTS-1:0] ok_q;
    logic [15:0]      dout_q;

    logic [SLOTS-1:0] pick_grant;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;

    logic             wr_done, ref_done, rd_accept, rd_done, ref_wrap;

    jtframe_rr_pick #(.N(SLOTS)) u_pick (
        .req   (bus.slot_req),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // An ack or rdy only means something in the state that waits for it.
    assign wr_done   = (state == ST_WRITE)   && bus.sdram_ack;
    assign ref_done  = (state == ST_REFRESH) && bus.sdram_ack;
    assign rd_accept = (state == ST_READ)    && bus.sdram_ack;
    assign rd_done   = (state == ST_RDWAIT)  && bus.sdram_rdy;
    assign ref_wrap  = (ref_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (wbuf_full) begin
                    state_nxt = ST_WRITE;
                end else if (ref_pend) begin
                    state_nxt = ST_REFRESH;
                end else if (!bus.downloading && pick_any) begin
                    state_nxt = ST_READ;
                end
            end
            ST_WRITE:   if (bus.sdram_ack) state_nxt = ST_IDLE;
            ST_REFRESH: if (bus.sdram_ack) state_nxt = ST_IDLE;
            ST_READ:    if (bus.sdram_ack) state_nxt = ST_RDWAIT;
            ST_RDWAIT:  if (bus.sdram_rdy) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Command strobes decode the state register, so they rise the cycle
    // after IDLE picks a request and fall the cycle after the ack.
    always_comb begin
        bus.sdram_rd      = (state == ST_READ);
        bus.sdram_wr      = (state == ST_WRITE);
        bus.sdram_refresh = (state == ST_REFRESH);
        bus.sdram_addr    = addr_q;
        bus.sdram_din     = din_q;
        bus.sdram_dqm     = dqm_q;
        bus.slot_ack      = rd_accept ? sel_oh : '0;
        bus.slot_ok       = ok_q;
        bus.slot_dout     = dout_q;
        bus.wr_overrun    = overrun_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbuf_full <= 1'b0;
            wbuf_addr <= '0;
            wbuf_data <= '0;
            overrun_q <= 1'b0;
            ref_cnt   <= '0;
            ref_pend  <= 1'b0;
            rr_ptr    <= '0;
            sel       <= '0;
            sel_oh    <= '0;
            addr_q    <= '0;
            din_q     <= '0;
            dqm_q     <= DQM_NONE;
            ok_q      <= '0;
            dout_q    <= '0;
        end else begin
            // A strobe arriving as the buffer drains refills it; otherwise
            // a strobe into a full buffer is lost and flagged.
            if (bus.ioctl_wr) begin
                if (!wbuf_full || wr_done) begin
                    wbuf_addr <= bus.ioctl_addr;
                    wbuf_data <= bus.ioctl_data;
                    wbuf_full <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (wr_done) begin
                wbuf_full <= 1'b0;
            end

            ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;
            // a new interval ending wins over the clear, so it is not lost
            if (ref_wrap) begin
                ref_pend <= 1'b1;
            end else if (ref_done) begin
                ref_pend <= 1'b0;
            end

            if (state == ST_IDLE && state_nxt == ST_WRITE) begin
                addr_q <= AW'({1'b0, wbuf_addr[21:1]});
                din_q  <= {wbuf_data, wbuf_data};
                dqm_q  <= wbuf_addr[0] ? DQM_WR_HIGH : DQM_WR_LOW;
            end else if (state == ST_IDLE && state_nxt == ST_READ) begin
                addr_q <= bus.slot_addr[pick_idx*AW +: AW];
                dqm_q  <= DQM_WORD;
                sel    <= pick_idx;
                sel_oh <= pick_grant;
            end

            ok_q <= rd_done ? sel_oh : '0;
            if (rd_done) begin
                dout_q <= bus.sdram_dout;
                rr_ptr <= (sel == IW'(SLOTS - 1)) ? '0 : sel + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jtframe_sdram_arbiter.sv
// tb/tb_jtframe_sdram_arbiter.sv - directed self-checking bench for jtframe_sdram_arbiter
module tb_jtframe_sdram_arbiter;

    localparam int SLOTS = 3;
    localparam int AW    = 22;
    localparam int RC    = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    jtframe_sdram_arbiter_if #(.SLOTS(SLOTS), .AW(AW)) bus();

    jtframe_sdram_arbiter #(.SLOTS(SLOTS), .AW(AW), .REFRESH_CYCLES(RC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int t        = 0;

    int          rr_slot [4] = '{0, 1, 2, 0};
    logic [21:0] rr_addr [4] = '{22'h000100, 22'h000200, 22'h000300, 22'h000100};
    logic [15:0] rr_data [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h0ABC};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        t++;
    endtask

    task automatic ack_cmd();
        bus.sdram_ack = 1'b1;
        step();
        bus.sdram_ack = 1'b0;
    endtask

    // kind: 0 timeout, 1 write, 2 read, 3 refresh
    task automatic get_cmd(input bit skip_ref, input int budget, output int kind);
        kind = 0;
        for (int n = 0; n < budget && kind == 0; n++) begin
            step();
            if (bus.sdram_refresh && skip_ref) ack_cmd();
            else if (bus.sdram_wr)             kind = 1;
            else if (bus.sdram_rd)             kind = 2;
            else if (bus.sdram_refresh)        kind = 3;
        end
    endtask

    task automatic wait_ref(input int budget, output int at);
        at = -1;
        for (int n = 0; n < budget && at < 0; n++) begin
            step();
            if (bus.sdram_refresh) at = t;
        end
    endtask

    task automatic watch(input int n, output int wr_seen, output int rd_seen, output int ref_seen);
        wr_seen = 0; rd_seen = 0; ref_seen = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (bus.sdram_wr) wr_seen++;
            if (bus.sdram_rd) rd_seen++;
            if (bus.sdram_refresh) begin
                ref_seen++;
                ack_cmd();
            end
        end
    endtask

    initial begin
        int kind, r1, r2, r3, nw, nr, nf;
        rst_n            = 1'b0;
        bus.downloading  = 1'b0;
        bus.ioctl_addr   = '0;
        bus.ioctl_data   = '0;
        bus.ioctl_wr     = 1'b0;
        bus.slot_addr    = '0;
        bus.slot_req     = '0;
        bus.sdram_ack    = 1'b0;
        bus.sdram_rdy    = 1'b0;
        bus.sdram_dout   = '0;
        repeat (3) step();

        check("rst_rd",      bus.sdram_rd, 0);
        check("rst_wr",      bus.sdram_wr, 0);
        check("rst_refresh", bus.sdram_refresh, 0);
        check("rst_addr",    bus.sdram_addr, 0);
        check("rst_din",     bus.sdram_din, 0);
        check("rst_dqm",     bus.sdram_dqm, 2'b11);
        check("rst_ok",      bus.slot_ok, 0);
        check("rst_ack",     bus.slot_ack, 0);
        check("rst_dout",    bus.slot_dout, 0);
        check("rst_overrun", bus.wr_overrun, 0);

        // refresh cadence with no other traffic
        rst_n = 1'b1;
        t = 0;
        wait_ref(40, r1);
        check("ref_first", r1, 17);
        ack_cmd();
        check("ref_drop", bus.sdram_refresh, 0);
        wait_ref(40, r2);
        check("ref_period1", r2 - r1, 16);
        ack_cmd();
        wait_ref(40, r3);
        check("ref_period2", r3 - r2, 16);
        ack_cmd();

        // download byte to odd address
        bus.ioctl_addr = 22'h000005; bus.ioctl_data = 8'hA5; bus.ioctl_wr = 1'b1;
        step();
        bus.ioctl_wr = 1'b0;
        get_cmd(1, 40, kind);
        check("dl_kind", kind, 1);
        check("dl_addr", bus.sdram_addr, 22'h000002);
        check("dl_din",  bus.sdram_din, 16'hA5A5);
        check("dl_dqm",  bus.sdram_dqm, 2'b01);
        ack_cmd();
        check("dl_wr_drop", bus.sdram_wr, 0);
        watch(24, nw, nr, nf);
        check("dl_no_rewrite", nw, 0);
        check("dl_no_overrun", bus.wr_overrun, 0);

        // overrun: second byte arrives while the first is still buffered
        bus.ioctl_addr = 22'h000010; bus.ioctl_data = 8'h3C; bus.ioctl_wr = 1'b1;
        step();
        bus.ioctl_wr = 1'b0;
        step();
        bus.ioctl_addr = 22'h000011; bus.ioctl_data = 8'h7E; bus.ioctl_wr = 1'b1;
        step();
        bus.ioctl_wr = 1'b0;
        step();
        check("ov_flag", bus.wr_overrun, 1);
        get_cmd(1, 40, kind);
        check("ov_kind", kind, 1);
        check("ov_addr", bus.sdram_addr, 22'h000008);
        check("ov_din",  bus.sdram_din, 16'h3C3C);
        check("ov_dqm",  bus.sdram_dqm, 2'b10);
        ack_cmd();
        watch(24, nw, nr, nf);
        check("ov_dropped", nw, 0);
        check("ov_sticky", bus.wr_overrun, 1);

        // round-robin with all slots requesting
        bus.slot_addr = {22'h000300, 22'h000200, 22'h000100};
        bus.slot_req  = 3'b111;
        for (int k = 0; k < 4; k++) begin
            get_cmd(1, 40, kind);
            check("rr_kind", kind, 2);
            check("rr_addr", bus.sdram_addr, rr_addr[k]);
            bus.sdram_ack = 1'b1;
            #1;
            check("rr_slot_ack", bus.slot_ack, 3'b001 << rr_slot[k]);
            step();
            bus.sdram_ack  = 1'b0;
            bus.sdram_dout = rr_data[k];
            bus.sdram_rdy  = 1'b1;
            step();
            bus.sdram_rdy  = 1'b0;
            check("rr_slot_ok", bus.slot_ok, 3'b001 << rr_slot[k]);
            check("rr_dout",    bus.slot_dout, rr_data[k]);
        end
        bus.slot_req = 3'b010;

        // refresh held off while a read waits for data
        get_cmd(1, 40, kind);
        check("rw_kind", kind, 2);
        check("rw_addr", bus.sdram_addr, 22'h000200);
        ack_cmd();
        watch(20, nw, nr, nf);
        check("rw_no_ref", nf, 0);
        check("ok_single_cycle", bus.slot_ok, 0);
        bus.slot_req   = 3'b000;
        bus.sdram_dout = 16'h5A5A;
        bus.sdram_rdy  = 1'b1;
        step();
        bus.sdram_rdy  = 1'b0;
        check("rw_ok",        bus.slot_ok, 3'b010);
        check("rw_ref_after", bus.sdram_refresh, 0);
        step();
        check("rw_ref_issued", bus.sdram_refresh, 1);
        ack_cmd();

        // priority: write, refresh and read all pending in IDLE
        bus.slot_req = 3'b100;
        get_cmd(1, 40, kind);
        check("pr_rd_kind", kind, 2);
        check("pr_rd_addr", bus.sdram_addr, 22'h000300);
        ack_cmd();
        bus.slot_req = 3'b001;
        bus.ioctl_addr = 22'h000020; bus.ioctl_data = 8'h11; bus.ioctl_wr = 1'b1;
        step();
        bus.ioctl_wr = 1'b0;
        watch(20, nw, nr, nf);
        check("pr_wait_nowr", nw, 0);
        bus.sdram_dout = 16'h7777;
        bus.sdram_rdy  = 1'b1;
        step();
        bus.sdram_rdy  = 1'b0;
        check("pr_dropped_req_ok", bus.slot_ok, 3'b100);
        check("pr_dout", bus.slot_dout, 16'h7777);
        get_cmd(0, 10, kind);
        check("pr_first_write", kind, 1);
        check("pr_wr_addr", bus.sdram_addr, 22'h000010);
        check("pr_wr_dqm", bus.sdram_dqm, 2'b10);
        ack_cmd();
        get_cmd(0, 10, kind);
        check("pr_second_refresh", kind, 3);
        ack_cmd();
        get_cmd(1, 40, kind);
        check("pr_third_read", kind, 2);
        check("pr_rd0_addr", bus.sdram_addr, 22'h000100);

        // downloading rises mid-read: read completes, no new reads start
        bus.downloading = 1'b1;
        bus.sdram_ack = 1'b1;
        #1;
        check("dlrd_ack", bus.slot_ack, 3'b001);
        step();
        bus.sdram_ack  = 1'b0;
        bus.sdram_dout = 16'h0123;
        bus.sdram_rdy  = 1'b1;
        step();
        bus.sdram_rdy  = 1'b0;
        check("dlrd_ok", bus.slot_ok, 3'b001);
        check("dlrd_dout", bus.slot_dout, 16'h0123);
        watch(24, nw, nr, nf);
        check("dlrd_blocked", nr, 0);
        bus.downloading = 1'b0;
        get_cmd(1, 40, kind);
        check("dlrd_resume", kind, 2);
        ack_cmd();

        // asynchronous reset while in RDWAIT
        rst_n = 1'b0;
        #1;
        check("rrst_rd",      bus.sdram_rd, 0);
        check("rrst_wr",      bus.sdram_wr, 0);
        check("rrst_refresh", bus.sdram_refresh, 0);
        check("rrst_addr",    bus.sdram_addr, 0);
        check("rrst_din",     bus.sdram_din, 0);
        check("rrst_dqm",     bus.sdram_dqm, 2'b11);
        check("rrst_dout",    bus.slot_dout, 0);
        check("rrst_overrun", bus.wr_overrun, 0);
        bus.slot_req = 3'b000;
        step();
        rst_n = 1'b1;
        bus.sdram_dout = 16'hDEAD;
        bus.sdram_rdy  = 1'b1;
        step();
        bus.sdram_rdy  = 1'b0;
        check("rrst_no_ok",   bus.slot_ok, 0);
        check("rrst_no_dout", bus.slot_dout, 0);
        step();
        check("rrst_no_ok2",  bus.slot_ok, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
